hpi_device_model: RTL and testbench
===================================

HPI_DEVICE_MODEL -- requirements
Module: hpi_device_model

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024 (power of two): number of 16-bit words in the internal memory.
REQ-002 SHALL have ports, clock and reset first:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- OTG_ADDR  in  2  HPI register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
- OTG_RD_N, OTG_WR_N, OTG_CS_N  in  1 each  active-low strobes, synchronous to Clk
- OTG_RST_N  in  1  active-low device reset
- OTG_DATA  inout  16  HPI data bus
- OTG_INT  out  1  high while the device-to-host mailbox is full
- dev_mbx_wdata  in  16  device-side mailbox write data
- dev_mbx_wr  in  1  device-side mailbox write strobe, one cycle
- dev_mbx_rdata  out  16  last value the host wrote to MAILBOX
- dev_mbx_valid  out  1  host-to-device mailbox pending
- dev_mbx_ack  in  1  device consumes the pending mailbox, one cycle

Function
REQ-003 SHALL register ADDR, RD_N, WR_N, CS_N and OTG_DATA-in through one flop stage; all decoding below uses the registered copies (r_*).
REQ-004 Access: read = r_CS_N=0, r_RD_N=0, r_WR_N=1; write = r_CS_N=0, r_WR_N=0, r_RD_N=1; both strobes low = no access, no bus drive.
REQ-005 SHALL drive OTG_DATA from a 16-bit read register only while a read is decoded; otherwise OTG_DATA SHALL be high-Z.
REQ-006 Read register SHALL load on the first cycle a read is decoded: DATA -> mem[ptr index]; MAILBOX -> outbound mailbox; ADDRESS -> ptr; STATUS -> {7'b0, MBX_IN, 7'b0, MBX_OUT}. It SHALL hold for the rest of the strobe. Bus valid 2 Clk after the host's RD_N falls.
REQ-007 While a write is decoded, SHALL capture r_OTG_DATA every cycle. On the first cycle after the write ends (write decoded last cycle, not this cycle), SHALL commit the last captured word to the register selected by the r_ADDR value of the final write cycle.
REQ-008 ptr: 16-bit byte address. Memory index = ptr[log2(MEM_WORDS):1]; index wraps modulo MEM_WORDS. ptr[0] ignored.
REQ-009 DATA access SHALL post-increment ptr by 2, modulo 2^16, at end of strobe (read-end cycle or write-commit cycle). ADDRESS write loads ptr with no increment.
REQ-010 Host MAILBOX write SHALL load dev_mbx_rdata, set MBX_IN and set dev_mbx_valid. If already set, SHALL overwrite and stay set.
REQ-011 dev_mbx_ack SHALL clear MBX_IN/dev_mbx_valid the next cycle. Same-cycle host MAILBOX commit and ack: set wins.
REQ-012 dev_mbx_wr SHALL load the outbound mailbox and set MBX_OUT. OTG_INT = MBX_OUT, registered.
REQ-013 Host MAILBOX read SHALL clear MBX_OUT at read end. Same-cycle dev_mbx_wr and clear: set wins; the new value is kept.
REQ-014 STATUS writes SHALL be ignored.

Reset
REQ-015 Reset=1 or registered OTG_RST_N=0 SHALL, at the next Clk edge, set: ptr=0, both mailboxes=0, MBX_IN=MBX_OUT=0, OTG_INT=0, dev_mbx_valid=0, dev_mbx_rdata=0, read register=0, bus high-Z, input flops to idle (strobes=1).
REQ-016 Reset SHALL NOT clear memory contents.
REQ-017 A strobe in progress at reset SHALL be abandoned: no commit and no increment after reset releases, until the strobe deasserts and a new one begins.

Configuration
REQ-018 Macro HPI_MAILBOX_EN defined: mailbox logic per REQ-010..013.
REQ-019 HPI_MAILBOX_EN undefined: MAILBOX reads return 0 and writes are ignored; STATUS reads 0; OTG_INT, dev_mbx_valid and dev_mbx_rdata are tied 0; dev_mbx_wr and dev_mbx_ack are ignored.

Verification
REQ-020 ADDRESS write 0x1000; DATA writes 0xAAAA, 0x5555; ADDRESS write 0x1000; two DATA reads -> return 0xAAAA, 0x5555; ADDRESS read -> 0x1004.
REQ-021 With MEM_WORDS=1024: ADDRESS write 0x07FE; DATA writes 0x1111, 0x2222 -> ptr=0x0802; mem[1023]=0x1111, mem[0]=0x2222 (index wrap). Repeat with ADDRESS=0xFFFE -> ptr wraps to 0x0000 after one DATA write.
REQ-022 dev_mbx_wr with 0xBEEF -> OTG_INT=1 and STATUS=0x0001; host MAILBOX read returns 0xBEEF -> OTG_INT=0 at read end. Repeat with dev_mbx_wr asserted on the read-end cycle -> OTG_INT stays 1.
REQ-023 Host MAILBOX write 0x1234 -> dev_mbx_valid=1, dev_mbx_rdata=0x1234, STATUS=0x0100; dev_mbx_ack -> valid=0. Ack on the same cycle as a second host write of 0x5678 -> valid stays 1, rdata=0x5678.
REQ-024 Reset pulsed mid DATA write -> no memory change, ptr=0, bus high-Z; memory written before reset is intact afterward. Any read -> OTG_DATA driven only during the strobe. RD_N=WR_N=0 together -> bus high-Z and no state change.
REQ-025 Build without HPI_MAILBOX_EN: dev_mbx_wr, then MAILBOX and STATUS reads -> both 0x0000; OTG_INT stays 0.

Source files
------------

// File: rtl/hpi_device_model.sv
// Behavioural HPI slave: address pointer, data window into internal RAM, host/device mailboxes.
// Mailbox logic exists only when HPI_MAILBOX_EN is defined; otherwise mailbox and status read as zero.
module hpi_device_model #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  OTG_ADDR,
    input  logic        OTG_RD_N,
    input  logic        OTG_WR_N,
    input  logic        OTG_CS_N,
    input  logic        OTG_RST_N,
    inout  wire  [15:0] OTG_DATA,
    output logic        OTG_INT,
    input  logic [15:0] dev_mbx_wdata,
    input  logic        dev_mbx_wr,
    output logic [15:0] dev_mbx_rdata,
    output logic        dev_mbx_valid,
    input  logic        dev_mbx_ack
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [1:0] SEL_DATA = 2'd0;
    localparam logic [1:0] SEL_MBX  = 2'd1;
    localparam logic [1:0] SEL_ADDR = 2'd2;
    localparam logic [1:0] SEL_STAT = 2'd3;

    logic        rst_n_reg;
    logic [1:0]  addr_reg;
    logic        rd_n_reg;
    logic        wr_n_reg;
    logic        cs_n_reg;
    logic [15:0] data_in_reg;
    logic        dev_rst;

    logic        abandon_reg;
    logic        post_rst_reg;
    logic        rd_prev_reg;
    logic        wr_prev_reg;
    logic [1:0]  rd_sel_reg;
    logic [1:0]  wr_sel_reg;
    logic [15:0] wr_data_reg;
    logic [15:0] ptr_reg;
    logic [15:0] read_reg;

    logic [15:0] mem [MEM_WORDS];
    logic [AW-1:0] mem_idx;

    logic        strobe_active;
    logic        read_dec;
    logic        write_dec;
    logic        read_start;
    logic        read_end;
    logic        write_commit;
    logic [15:0] mbx_rd_value;
    logic [15:0] status_value;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rst_n_reg <= 1'b1;
        end else begin
            rst_n_reg <= OTG_RST_N;
        end
    end

    assign dev_rst = Reset | ~rst_n_reg;

    always_ff @(posedge Clk) begin
        if (dev_rst) begin
            addr_reg    <= 2'd0;
            rd_n_reg    <= 1'b1;
            wr_n_reg    <= 1'b1;
            cs_n_reg    <= 1'b1;
            data_in_reg <= 16'h0000;
        end else begin
            addr_reg    <= OTG_ADDR;
            rd_n_reg    <= OTG_RD_N;
            wr_n_reg    <= OTG_WR_N;
            cs_n_reg    <= OTG_CS_N;
            data_in_reg <= OTG_DATA;
        end
    end

    assign mem_idx       = ptr_reg[AW:1];
    assign strobe_active = ~cs_n_reg & (~rd_n_reg | ~wr_n_reg);
    assign read_dec      = ~cs_n_reg & ~rd_n_reg &  wr_n_reg & ~abandon_reg;
    assign write_dec     = ~cs_n_reg & ~wr_n_reg &  rd_n_reg & ~abandon_reg;
    assign read_start    = read_dec & ~rd_prev_reg;
    assign read_end      = rd_prev_reg & ~read_dec;
    assign write_commit  = wr_prev_reg & ~write_dec;

    // A strobe still held across reset stays ignored until the host releases it;
    // post_rst_reg skips the first post-reset cycle whose flops hold reset values.
    always_ff @(posedge Clk) begin
        if (dev_rst) begin
            abandon_reg  <= 1'b1;
            post_rst_reg <= 1'b1;
            rd_prev_reg  <= 1'b0;
            wr_prev_reg  <= 1'b0;
            rd_sel_reg   <= SEL_DATA;
            wr_sel_reg   <= SEL_DATA;
            wr_data_reg  <= 16'h0000;
            ptr_reg      <= 16'h0000;
            read_reg     <= 16'h0000;
        end else begin
            post_rst_reg <= 1'b0;
            if (!post_rst_reg && !strobe_active) begin
                abandon_reg <= 1'b0;
            end
            rd_prev_reg <= read_dec;
            wr_prev_reg <= write_dec;
            if (write_dec) begin
                wr_data_reg <= data_in_reg;
                wr_sel_reg  <= addr_reg;
            end
            if (read_start) begin
                rd_sel_reg <= addr_reg;
                case (addr_reg)
                    SEL_DATA: read_reg <= mem[mem_idx];
                    SEL_MBX:  read_reg <= mbx_rd_value;
                    SEL_ADDR: read_reg <= ptr_reg;
                    default:  read_reg <= status_value;
                endcase
            end
            if (read_end && rd_sel_reg == SEL_DATA) begin
                ptr_reg <= ptr_reg + 16'd2;
            end
            if (write_commit) begin
                if (wr_sel_reg == SEL_DATA) begin
                    ptr_reg <= ptr_reg + 16'd2;
                end else if (wr_sel_reg == SEL_ADDR) begin
                    ptr_reg <= wr_data_reg;
                end
            end
        end
    end

    // Memory has no reset so contents survive both reset sources.
    always_ff @(posedge Clk) begin
        if (!dev_rst && write_commit && wr_sel_reg == SEL_DATA) begin
            mem[mem_idx] <= wr_data_reg;
        end
    end

    assign OTG_DATA = read_dec ? read_reg : 16'hzzzz;

`ifdef HPI_MAILBOX_EN
    logic        mbx_in_reg;
    logic        mbx_out_reg;
    logic [15:0] mbx_in_data_reg;
    logic [15:0] mbx_out_data_reg;

    always_ff @(posedge Clk) begin
        if (dev_rst) begin
            mbx_in_reg       <= 1'b0;
            mbx_out_reg      <= 1'b0;
            mbx_in_data_reg  <= 16'h0000;
            mbx_out_data_reg <= 16'h0000;
        end else begin
            if (write_commit && wr_sel_reg == SEL_MBX) begin
                mbx_in_data_reg <= wr_data_reg;
                mbx_in_reg      <= 1'b1;
            end else if (dev_mbx_ack) begin
                mbx_in_reg <= 1'b0;
            end
            if (dev_mbx_wr) begin
                mbx_out_data_reg <= dev_mbx_wdata;
                mbx_out_reg      <= 1'b1;
            end else if (read_end && rd_sel_reg == SEL_MBX) begin
                mbx_out_reg <= 1'b0;
            end
        end
    end

    assign mbx_rd_value  = mbx_out_data_reg;
    assign status_value  = {7'b0, mbx_in_reg, 7'b0, mbx_out_reg};
    assign OTG_INT       = mbx_out_reg;
    assign dev_mbx_valid = mbx_in_reg;
    assign dev_mbx_rdata = mbx_in_data_reg;
`else
    logic unused_mbx;

    assign unused_mbx    = ^{dev_mbx_wdata, dev_mbx_wr, dev_mbx_ack};
    assign mbx_rd_value  = 16'h0000;
    assign status_value  = 16'h0000;
    assign OTG_INT       = 1'b0;
    assign dev_mbx_valid = 1'b0;
    assign dev_mbx_rdata = 16'h0000;
`endif

endmodule

// File: tb/tb_hpi_device_model.sv
// Directed bench for hpi_device_model; expected read data queued at strobe start, checked when the bus is valid.
module tb_hpi_device_model;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  OTG_ADDR = 2'd0;
    logic        OTG_RD_N = 1'b1;
    logic        OTG_WR_N = 1'b1;
    logic        OTG_CS_N = 1'b1;
    logic        OTG_RST_N = 1'b1;
    wire  [15:0] otg_data;
    logic        OTG_INT;
    logic [15:0] dev_mbx_wdata = 16'h0000;
    logic        dev_mbx_wr = 1'b0;
    logic [15:0] dev_mbx_rdata;
    logic        dev_mbx_valid;
    logic        dev_mbx_ack = 1'b0;

    logic        tb_oe = 1'b0;
    logic [15:0] tb_wdata = 16'h0000;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_MBX  = 2'd1;
    localparam logic [1:0] A_ADDR = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;
    // Undriven bus floats to all ones through the pullup.
    localparam logic [15:0] BUS_IDLE = 16'hFFFF;

    pullup (otg_data);
    assign otg_data = tb_oe ? tb_wdata : 16'hzzzz;

    always #5 Clk = ~Clk;

    hpi_device_model #(.MEM_WORDS(1024)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .OTG_ADDR      (OTG_ADDR),
        .OTG_RD_N      (OTG_RD_N),
        .OTG_WR_N      (OTG_WR_N),
        .OTG_CS_N      (OTG_CS_N),
        .OTG_RST_N     (OTG_RST_N),
        .OTG_DATA      (otg_data),
        .OTG_INT       (OTG_INT),
        .dev_mbx_wdata (dev_mbx_wdata),
        .dev_mbx_wr    (dev_mbx_wr),
        .dev_mbx_rdata (dev_mbx_rdata),
        .dev_mbx_valid (dev_mbx_valid),
        .dev_mbx_ack   (dev_mbx_ack)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [1:0] a, input logic [15:0] d, input bit ack_end);
        OTG_ADDR = a;
        tb_wdata = d;
        tb_oe    = 1'b1;
        OTG_CS_N = 1'b0;
        OTG_WR_N = 1'b0;
        tick(2);
        OTG_WR_N = 1'b1;
        OTG_CS_N = 1'b1;
        tb_oe    = 1'b0;
        tick(1);
        if (ack_end) dev_mbx_ack = 1'b1;
        tick(1);
        dev_mbx_ack = 1'b0;
        $display("WR sel=%0d data=%h ack_on_commit=%0d", a, d, ack_end);
    endtask

    task automatic host_read(input logic [1:0] a, input logic [15:0] exp, input string tag,
                             input bit wr_end);
        logic [15:0] e;
        logic [15:0] obs;
        exp_q.push_back(exp);
        OTG_ADDR = a;
        OTG_CS_N = 1'b0;
        OTG_RD_N = 1'b0;
        tick(2);
        obs = otg_data;
        e = exp_q.pop_front();
        chk(tag, obs, e);
        OTG_RD_N = 1'b1;
        OTG_CS_N = 1'b1;
        tick(1);
        if (wr_end) begin
            dev_mbx_wdata = 16'hC0DE;
            dev_mbx_wr    = 1'b1;
        end
        tick(1);
        dev_mbx_wr = 1'b0;
        $display("RD sel=%0d data=%h exp=%h", a, obs, e);
    endtask

    task automatic dev_write(input logic [15:0] d);
        dev_mbx_wdata = d;
        dev_mbx_wr    = 1'b1;
        tick(1);
        dev_mbx_wr = 1'b0;
        $display("DEV WR data=%h", d);
    endtask

    initial begin
        tick(3);
        Reset = 1'b0;
        tick(1);
        chk("reset_bus", otg_data, BUS_IDLE);
        chk("reset_int", {15'b0, OTG_INT}, 16'h0000);
        chk("reset_valid", {15'b0, dev_mbx_valid}, 16'h0000);
        chk("reset_rdata", dev_mbx_rdata, 16'h0000);
        host_read(A_ADDR, 16'h0000, "reset_ptr", 1'b0);

        // Basic write/readback with post-increment
        host_write(A_ADDR, 16'h1000, 1'b0);
        host_write(A_DATA, 16'hAAAA, 1'b0);
        host_write(A_DATA, 16'h5555, 1'b0);
        host_write(A_ADDR, 16'h1000, 1'b0);
        host_read(A_DATA, 16'hAAAA, "rd_aaaa", 1'b0);
        chk("bus_after_read", otg_data, BUS_IDLE);
        host_read(A_DATA, 16'h5555, "rd_5555", 1'b0);
        host_read(A_ADDR, 16'h1004, "ptr_1004", 1'b0);

        // ptr[0] is ignored for indexing but kept in the pointer
        host_write(A_ADDR, 16'h1001, 1'b0);
        host_read(A_DATA, 16'hAAAA, "odd_ptr_rd", 1'b0);
        host_read(A_ADDR, 16'h1003, "odd_ptr_inc", 1'b0);

        // Memory index wrap and 16-bit pointer wrap
        host_write(A_ADDR, 16'h07FE, 1'b0);
        host_write(A_DATA, 16'h1111, 1'b0);
        host_write(A_DATA, 16'h2222, 1'b0);
        host_read(A_ADDR, 16'h0802, "ptr_0802", 1'b0);
        host_write(A_ADDR, 16'h07FE, 1'b0);
        host_read(A_DATA, 16'h1111, "mem1023", 1'b0);
        host_read(A_DATA, 16'h2222, "mem_wrap", 1'b0);
        host_write(A_ADDR, 16'h0000, 1'b0);
        host_read(A_DATA, 16'h2222, "mem0", 1'b0);
        host_write(A_ADDR, 16'hFFFE, 1'b0);
        host_write(A_DATA, 16'h3333, 1'b0);
        host_read(A_ADDR, 16'h0000, "ptr_wrap", 1'b0);
        host_write(A_ADDR, 16'h07FE, 1'b0);
        host_read(A_DATA, 16'h3333, "mem_alias", 1'b0);

        // Both strobes low: no access, no drive, no pointer change
        host_write(A_ADDR, 16'h0200, 1'b0);
        OTG_ADDR = A_DATA;
        OTG_CS_N = 1'b0;
        OTG_RD_N = 1'b0;
        OTG_WR_N = 1'b0;
        tick(3);
        chk("both_low_bus", otg_data, BUS_IDLE);
        OTG_RD_N = 1'b1;
        OTG_WR_N = 1'b1;
        OTG_CS_N = 1'b1;
        tick(2);
        $display("BOTH strobes low on DATA");
        host_read(A_ADDR, 16'h0200, "both_low_ptr", 1'b0);

        // Reset in the middle of a DATA write
        host_write(A_ADDR, 16'h0100, 1'b0);
        host_write(A_DATA, 16'hCAFE, 1'b0);
        host_write(A_DATA, 16'h0BAD, 1'b0);
        host_write(A_ADDR, 16'h0102, 1'b0);
        OTG_ADDR = A_DATA;
        tb_wdata = 16'hDEAD;
        tb_oe    = 1'b1;
        OTG_CS_N = 1'b0;
        OTG_WR_N = 1'b0;
        tick(1);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        tick(3);
        OTG_WR_N = 1'b1;
        OTG_CS_N = 1'b1;
        tb_oe    = 1'b0;
        tick(3);
        $display("RESET during DATA write data=%h", tb_wdata);
        chk("rst_mid_bus", otg_data, BUS_IDLE);
        host_read(A_ADDR, 16'h0000, "rst_mid_ptr", 1'b0);
        host_write(A_ADDR, 16'h0100, 1'b0);
        host_read(A_DATA, 16'hCAFE, "rst_keep0", 1'b0);
        host_read(A_DATA, 16'h0BAD, "rst_keep1", 1'b0);

        // Host-side device reset pin
        host_write(A_ADDR, 16'h0400, 1'b0);
        OTG_RST_N = 1'b0;
        tick(1);
        OTG_RST_N = 1'b1;
        tick(3);
        $display("OTG_RST_N pulse");
        host_read(A_ADDR, 16'h0000, "otg_rst_ptr", 1'b0);

`ifdef HPI_MAILBOX_EN
        dev_write(16'hBEEF);
        chk("int_set", {15'b0, OTG_INT}, 16'h0001);
        host_read(A_STAT, 16'h0001, "status_out", 1'b0);
        host_read(A_MBX, 16'hBEEF, "mbx_beef", 1'b0);
        chk("int_clr", {15'b0, OTG_INT}, 16'h0000);
        dev_write(16'h1111);
        host_read(A_MBX, 16'h1111, "mbx_1111", 1'b1);
        chk("int_set_wins", {15'b0, OTG_INT}, 16'h0001);
        host_read(A_MBX, 16'hC0DE, "mbx_new_kept", 1'b0);
        chk("int_clr2", {15'b0, OTG_INT}, 16'h0000);

        host_write(A_MBX, 16'h1234, 1'b0);
        chk("valid_set", {15'b0, dev_mbx_valid}, 16'h0001);
        chk("rdata_1234", dev_mbx_rdata, 16'h1234);
        host_read(A_STAT, 16'h0100, "status_in", 1'b0);
        dev_mbx_ack = 1'b1;
        tick(1);
        dev_mbx_ack = 1'b0;
        $display("DEV ACK");
        chk("valid_clr", {15'b0, dev_mbx_valid}, 16'h0000);
        host_write(A_MBX, 16'h5678, 1'b1);
        chk("valid_set_wins", {15'b0, dev_mbx_valid}, 16'h0001);
        chk("rdata_5678", dev_mbx_rdata, 16'h5678);
`else
        dev_write(16'hBEEF);
        chk("nombx_int", {15'b0, OTG_INT}, 16'h0000);
        host_read(A_MBX, 16'h0000, "nombx_mbx", 1'b0);
        host_read(A_STAT, 16'h0000, "nombx_status", 1'b0);
        host_write(A_MBX, 16'h1234, 1'b0);
        chk("nombx_valid", {15'b0, dev_mbx_valid}, 16'h0000);
        chk("nombx_rdata", dev_mbx_rdata, 16'h0000);
        chk("nombx_int2", {15'b0, OTG_INT}, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
